// File: rtl/ctrl_mon_pkg.sv
// ctrl_mon_pkg: shared FSM states, retire classes, err_code bit indices and timeout constant
package ctrl_mon_pkg;
  typedef enum logic [1:0] {MON_IDLE, MON_ACTIVE, MON_HALT} mon_state_t;
  typedef enum logic [2:0] {CLS_NONE = 3'd0, CLS_DP = 3'd1, CLS_LDR = 3'd2, CLS_STR = 3'd3, CLS_BR = 3'd4} instr_class_t;
  localparam int ERR_MULTI = 0;
  localparam int ERR_TIMEOUT = 1;
  localparam int ERR_DUAL = 2;
  localparam int ERR_STRADR = 3;
  localparam logic [2:0] TIMEOUT_CYC = 3'd6;
endpackage

// File: rtl/ctrl_mon_if.sv
// ctrl_mon_if: multicycle controller outputs; master drives them, slave (the monitor) observes them
interface ctrl_mon_if;
  logic PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0] RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
  modport master (output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl);
  modport slave (input PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter with enable that sticks at all-ones, async active-low reset
module sat_counter #(parameter int W = 16) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else if (en && !(&q)) q <= q + W'(1);
endmodule

// File: rtl/ctrl_mon.sv
// ctrl_mon: retire/class/cycle monitor for a multicycle controller; CTRL_MON_CPI_EN adds total_cycles/total_instr
module ctrl_mon import ctrl_mon_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  ctrl_mon_if.slave   ctrl,
  output logic        instr_done,
  output logic [2:0]  instr_class,
  output logic [2:0]  instr_cycles,
  output logic [15:0] dp_count,
  output logic [15:0] ldr_count,
  output logic [15:0] str_count,
  output logic [15:0] br_count,
  output logic [15:0] none_count,
  output logic [3:0]  err_code,
  output logic        err
`ifdef CTRL_MON_CPI_EN
  ,
  output logic [31:0] total_cycles,
  output logic [31:0] total_instr
`endif
);
  mon_state_t state, state_d;
  instr_class_t cls, cls_d, ev_cls;
  logic [2:0] cyc, cyc_d, class_d, cycles_d;
  logic [3:0] err_d;
  logic retire, multi, ev_str, ev_ldr, ev_dp, ev_br, dual;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= MON_IDLE;
      cyc <= '0;
      cls <= CLS_NONE;
      err_code <= '0;
      instr_done <= 1'b0;
      instr_class <= '0;
      instr_cycles <= '0;
    end else begin
      state <= state_d;
      cyc <= cyc_d;
      cls <= cls_d;
      err_code <= err_d;
      instr_done <= retire;
      instr_class <= class_d;
      instr_cycles <= cycles_d;
    end
  always_comb begin
    state_d = state;
    cyc_d = cyc;
    cls_d = cls;
    err_d = err_code;
    class_d = instr_class;
    cycles_d = instr_cycles;
    retire = 1'b0;
    multi = ctrl.MemWrite & ctrl.RegWrite;
    ev_str = ctrl.MemWrite & ~multi;
    ev_ldr = ctrl.RegWrite & ~multi & (ctrl.ResultSrc == 2'b01);
    ev_dp = ctrl.RegWrite & ~multi & (ctrl.ResultSrc == 2'b00);
    ev_br = ctrl.PCWrite;
    ev_cls = ev_str ? CLS_STR : ev_ldr ? CLS_LDR : ev_dp ? CLS_DP : ev_br ? CLS_BR : CLS_NONE;
    dual = (ev_cls != CLS_NONE) && ((cls != CLS_NONE) || (ev_br && ev_cls != CLS_BR));
    if (state != MON_HALT) begin
      err_d[ERR_MULTI] = err_code[ERR_MULTI] | multi;
      err_d[ERR_STRADR] = err_code[ERR_STRADR] | (ctrl.MemWrite & ~ctrl.AdrSrc);
    end
    case (state)
      MON_IDLE:
        if (ctrl.IRWrite) begin
          state_d = MON_ACTIVE;
          cyc_d = 3'd1;
          cls_d = CLS_NONE;
        end
      MON_ACTIVE:
        if (ctrl.IRWrite) begin
          retire = 1'b1;
          class_d = cls;
          cycles_d = cyc;
          cyc_d = 3'd1;
          cls_d = CLS_NONE;
        end else if (cyc == TIMEOUT_CYC) begin
          err_d[ERR_TIMEOUT] = 1'b1;
          state_d = MON_HALT;
        end else begin
          cyc_d = cyc + 3'd1;
          cls_d = (cls == CLS_NONE) ? ev_cls : cls;
          err_d[ERR_DUAL] = err_code[ERR_DUAL] | dual;
        end
      default: ;
    endcase
  end
  assign err = |err_code;
  sat_counter #(.W(16)) u_dp (.clk(clk), .reset(reset), .en(retire && cls == CLS_DP), .q(dp_count));
  sat_counter #(.W(16)) u_ldr (.clk(clk), .reset(reset), .en(retire && cls == CLS_LDR), .q(ldr_count));
  sat_counter #(.W(16)) u_str (.clk(clk), .reset(reset), .en(retire && cls == CLS_STR), .q(str_count));
  sat_counter #(.W(16)) u_br (.clk(clk), .reset(reset), .en(retire && cls == CLS_BR), .q(br_count));
  sat_counter #(.W(16)) u_none (.clk(clk), .reset(reset), .en(retire && cls == CLS_NONE), .q(none_count));
`ifdef CTRL_MON_CPI_EN
  sat_counter #(.W(32)) u_tcyc (.clk(clk), .reset(reset), .en(state == MON_ACTIVE), .q(total_cycles));
  sat_counter #(.W(32)) u_tins (.clk(clk), .reset(reset), .en(retire), .q(total_instr));
`endif
endmodule

// File: tb/tb_ctrl_mon.sv
// tb_ctrl_mon: directed vectors with hand-computed expectations for ctrl_mon
module tb_ctrl_mon;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic instr_done, err;
  logic [2:0] instr_class, instr_cycles;
  logic [15:0] dp_count, ldr_count, str_count, br_count, none_count;
  logic [3:0] err_code;
`ifdef CTRL_MON_CPI_EN
  logic [31:0] total_cycles, total_instr;
`endif
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  ctrl_mon_if bus ();
  ctrl_mon dut (
    .clk(clk), .reset(reset), .ctrl(bus),
    .instr_done(instr_done), .instr_class(instr_class), .instr_cycles(instr_cycles),
    .dp_count(dp_count), .ldr_count(ldr_count), .str_count(str_count),
    .br_count(br_count), .none_count(none_count), .err_code(err_code), .err(err)
`ifdef CTRL_MON_CPI_EN
    , .total_cycles(total_cycles), .total_instr(total_instr)
`endif
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic ir, input logic pc, input logic mw, input logic rw, input logic adr, input logic [1:0] rs);
    bus.IRWrite = ir;
    bus.PCWrite = pc;
    bus.MemWrite = mw;
    bus.RegWrite = rw;
    bus.AdrSrc = adr;
    bus.ResultSrc = rs;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 1, 2'b00);
  endtask
  task automatic fetch();
    drive(1, 0, 0, 0, 1, 2'b00);
  endtask
  initial begin
    bus.RegSrc = '0;
    bus.ALUSrcA = '0;
    bus.ALUSrcB = '0;
    bus.ImmSrc = '0;
    bus.ALUControl = '0;
    idle(2);
    check("rst_done", 16'(instr_done), 16'd0);
    check("rst_class", 16'(instr_class), 16'd0);
    check("rst_err", 16'(err_code), 16'd0);
    reset = 1'b1;
    fetch();
    idle(1);
    drive(0, 0, 0, 1, 1, 2'b00);
    fetch();
    check("dp_done", 16'(instr_done), 16'd1);
    check("dp_class", 16'(instr_class), 16'd1);
    check("dp_cycles", 16'(instr_cycles), 16'd3);
    check("dp_count", dp_count, 16'd1);
    idle(1);
    check("done_pulse", 16'(instr_done), 16'd0);
    check("class_hold", 16'(instr_class), 16'd1);
    idle(2);
    drive(0, 0, 0, 1, 1, 2'b01);
    fetch();
    check("ldr_class", 16'(instr_class), 16'd2);
    check("ldr_cycles", 16'(instr_cycles), 16'd5);
    check("ldr_count", ldr_count, 16'd1);
    check("ldr_err", 16'(err), 16'd0);
    idle(2);
    drive(0, 0, 1, 0, 1, 2'b00);
    fetch();
    check("str_class", 16'(instr_class), 16'd3);
    check("str_cycles", 16'(instr_cycles), 16'd4);
    check("str_count", str_count, 16'd1);
    idle(1);
    drive(0, 1, 0, 0, 1, 2'b00);
    fetch();
    check("br_class", 16'(instr_class), 16'd4);
    check("br_cycles", 16'(instr_cycles), 16'd3);
    check("br_count", br_count, 16'd1);
    idle(1);
    fetch();
    check("none_class", 16'(instr_class), 16'd0);
    check("none_count", none_count, 16'd1);
    check("clean_err", 16'(err_code), 16'd0);
    drive(0, 0, 1, 1, 1, 2'b00);
    fetch();
    check("multi_err", 16'(err_code), 16'b0001);
    check("multi_class", 16'(instr_class), 16'd0);
    check("multi_none", none_count, 16'd2);
    drive(0, 0, 1, 0, 0, 2'b00);
    fetch();
    check("stradr_err", 16'(err_code), 16'b1001);
    check("stradr_str", str_count, 16'd2);
    drive(0, 0, 0, 1, 1, 2'b00);
    drive(0, 0, 1, 0, 1, 2'b00);
    fetch();
    check("dual_err", 16'(err_code), 16'b1101);
    check("dual_class", 16'(instr_class), 16'd1);
    check("dual_cycles", 16'(instr_cycles), 16'd3);
    check("dual_dp", dp_count, 16'd2);
    idle(5);
    check("pre_timeout", 16'(err_code), 16'b1101);
    idle(1);
    check("timeout_err", 16'(err_code), 16'b1111);
    check("timeout_flag", 16'(err), 16'd1);
    drive(0, 0, 0, 1, 1, 2'b00);
    fetch();
    check("halt_done", 16'(instr_done), 16'd0);
    check("halt_dp", dp_count, 16'd2);
    check("halt_class", 16'(instr_class), 16'd1);
    #2 reset = 1'b0;
    #1;
    check("async_err", 16'(err_code), 16'd0);
    check("async_str", str_count, 16'd0);
    check("async_class", 16'(instr_class), 16'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    fetch();
    idle(1);
    drive(0, 0, 0, 1, 1, 2'b01);
    #2 reset = 1'b0;
    #1;
    check("midldr_done", 16'(instr_done), 16'd0);
    check("midldr_ldr", ldr_count, 16'd0);
    drive(1, 0, 0, 0, 1, 2'b00);
    check("rst_nodone", 16'(instr_done), 16'd0);
    reset = 1'b1;
    fetch();
    idle(1);
    drive(0, 0, 0, 1, 1, 2'b00);
    fetch();
    check("post_done", 16'(instr_done), 16'd1);
    check("post_cycles", 16'(instr_cycles), 16'd3);
    check("post_dp", dp_count, 16'd1);
    check("post_ldr", ldr_count, 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ctrl_mon.md
CTRL_MON -- requirements
Module: ctrl_mon

Interface
REQ-001 SHALL provide `clk`, input, 1: the single clock; all state updates on its rising edge.
REQ-002 SHALL provide `reset`, input, 1: asynchronous, active-low reset (0 = reset).
REQ-003 SHALL accept these controller outputs, each an input of the given width:
- PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc: 1 bit each.
- RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl: 2 bits each.
REQ-004 SHALL provide `instr_done`, output, 1: one-cycle pulse when an instruction retires.
REQ-005 SHALL provide `instr_class`, output, 3: class of the retired instruction; NONE=0, DP=1, LDR=2, STR=3, BR=4.
REQ-006 SHALL provide `instr_cycles`, output, 3: cycle count of the retired instruction.
REQ-007 SHALL provide `dp_count`, `ldr_count`, `str_count`, `br_count`, `none_count`, outputs, 16 each: retire counters per class.
REQ-008 SHALL provide `err_code`, output, 4: sticky error bitmask.
- bit0 MULTI: MemWrite and RegWrite both high in one cycle.
- bit1 TIMEOUT: instruction not retired in time.
- bit2 DUALCLASS: second class event in one instruction.
- bit3 STRADR: MemWrite high with AdrSrc=0.
REQ-009 SHALL provide `err`, output, 1: OR-reduction of err_code.

Function
REQ-010 SHALL implement the FSM states MON_IDLE, MON_ACTIVE and MON_HALT.
REQ-011 In MON_IDLE, IRWrite=1 SHALL move to MON_ACTIVE with cyc=1 and the class latch cleared to NONE.
REQ-012 In MON_ACTIVE with IRWrite=0, cyc SHALL increment by 1 per cycle.
REQ-013 Class events in MON_ACTIVE with IRWrite=0:
- MemWrite sets STR.
- RegWrite with ResultSrc=01 sets LDR.
- RegWrite with ResultSrc=00 sets DP.
- PCWrite sets BR.
REQ-014 A class event SHALL latch only if the latch holds NONE; otherwise it SHALL set DUALCLASS and leave the latch unchanged.
REQ-015 IRWrite=1 in MON_ACTIVE SHALL retire the current instruction, and on the next edge SHALL:
- pulse instr_done;
- present the latched class and cyc;
- increment the matching counter;
- restart with cyc=1 and class NONE.
REQ-016 Retire latency SHALL be exactly 1 cycle after the fetch edge.
REQ-017 instr_class and instr_cycles SHALL hold their values between retirements.
REQ-018 When cyc=6 with IRWrite=0 (more than 5 cycles without a fetch), the block SHALL set TIMEOUT and enter MON_HALT.
REQ-019 MON_HALT SHALL freeze cyc and all counters and ignore inputs until reset.
REQ-020 MULTI and STRADR SHALL be checked every cycle in MON_IDLE and MON_ACTIVE.
REQ-021 A cycle with MemWrite=RegWrite=1 SHALL set MULTI and latch no class.
REQ-022 Counters SHALL saturate at 16'hFFFF.
REQ-023 err_code bits SHALL only ever set, never self-clear.

Reset
REQ-024 reset=0 SHALL asynchronously force: state MON_IDLE, cyc=0, class latch NONE, every output 0.
REQ-025 A reset asserted mid-instruction SHALL discard that instruction without pulsing instr_done.
REQ-026 The first IRWrite after reset release SHALL behave per REQ-011.

Configuration
REQ-027 With CTRL_MON_CPI_EN defined, the block SHALL add:
- output `total_cycles`, 32 bits: cycles spent in MON_ACTIVE;
- output `total_instr`, 32 bits: retired instructions.
Both SHALL saturate and reset to 0.
REQ-028 Without CTRL_MON_CPI_EN, these ports and their logic SHALL be absent.

Structure
REQ-029 A shared package ctrl_mon_pkg SHALL hold the FSM state enum, the instr_class enum, the err_code bit indices and the timeout constant (6).
REQ-030 A sub-module sat_counter, parameterized by width, SHALL implement all saturating counters.

Verification
REQ-031 DP: IRWrite, decode, RegWrite with ResultSrc=00, then IRWrite -> instr_done with class=1, cycles=3, dp_count=1.
REQ-032 LDR: IRWrite, 3 idle cycles, RegWrite with ResultSrc=01, then IRWrite -> class=2, cycles=5, ldr_count=1, err=0.
REQ-033 STR and BR:
- STR with AdrSrc=1 in 4 cycles -> class=3, cycles=4.
- A PCWrite-only instruction in 3 cycles -> class=4, br_count=1.
- An instruction with no class event (branch not taken) -> class=0, none_count=1.
REQ-034 Errors:
- MemWrite=RegWrite=1 -> err_code=4'b0001.
- MemWrite with AdrSrc=0 -> bit3 set.
- DP event followed by an STR event -> bit2 set, class stays DP.
REQ-035 Timeout: IRWrite, then 6 cycles with IRWrite=0 -> err_code bit1 set, FSM in MON_HALT, a later IRWrite produces no instr_done.
REQ-036 Reset: reset=0 mid-LDR -> all outputs 0 immediately, no instr_done; after release, a 3-cycle DP -> dp_count=1.
